// File: rtl/pc_gen_btb_if.sv
// Interface between the fetch-PC generator and the rest of the pipeline.
// Redirect and training inputs go into the PC stage; the fetch PC and the prediction come out.
interface pc_gen_btb_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            flush_i;
    logic [XLEN-1:0] flush_pc_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic [XLEN-1:0] pc_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;

    modport master (
        output stall_i, flush_i, flush_pc_i, redirect_i, redirect_pc_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  pc_o, pred_taken_o, pred_target_o
    );

    modport slave (
        input  stall_i, flush_i, flush_pc_i, redirect_i, redirect_pc_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output pc_o, pred_taken_o, pred_target_o
    );
endinterface

// File: rtl/pc_gen_btb.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Redirects and flushes override stall; EX trains the BTB independently of the PC path.
module pc_gen_btb #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 8,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              INST_BYTES  = 4
) (
    input logic         clk,
    input logic         rst,
    pc_gen_btb_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [BTB_ENTRIES-1:0] valid;
    logic [1:0]             ctr     [BTB_ENTRIES];
    tag_t                   tags    [BTB_ENTRIES];
    logic [XLEN-1:0]        targets [BTB_ENTRIES];

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    idx_t            look_idx;
    tag_t            look_tag;
    idx_t            upd_idx;
    tag_t            upd_tag;
    logic            hit;
    logic            upd_hit;
    logic            unused_low_bits;

    assign look_idx = pc[IDX_W+1:2];
    assign look_tag = pc[XLEN-1:IDX_W+2];
    assign upd_idx  = bus.upd_pc_i[IDX_W+1:2];
    assign upd_tag  = bus.upd_pc_i[XLEN-1:IDX_W+2];
    assign unused_low_bits = ^bus.upd_pc_i[1:0];

    // Lookup reads the registered PC and pre-update BTB contents only.
    assign hit     = valid[look_idx] && (tags[look_idx] == look_tag);
    assign upd_hit = valid[upd_idx] && (tags[upd_idx] == upd_tag);

    assign bus.pc_o          = pc;
    assign bus.pred_taken_o  = hit && ctr[look_idx][1];
    assign bus.pred_target_o = hit ? targets[look_idx] : '0;

    always_comb begin
        next_pc = pc + XLEN'(INST_BYTES);
        if (bus.flush_i) begin
            next_pc = bus.flush_pc_i;
        end else if (bus.redirect_i) begin
            next_pc = bus.redirect_pc_i;
        end else if (bus.stall_i) begin
            next_pc = pc;
        end else if (bus.pred_taken_o) begin
            next_pc = bus.pred_target_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Valid bits and counters reset to weakly not-taken; a miss allocates as weakly taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
        end else if (bus.upd_valid_i) begin
            if (upd_hit) begin
                if (bus.upd_taken_i) begin
                    if (ctr[upd_idx] != 2'b11) begin
                        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
                    end
                end else if (ctr[upd_idx] != 2'b00) begin
                    ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
                end
            end else if (bus.upd_taken_i) begin
                valid[upd_idx] <= 1'b1;
                ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tags and targets need no reset; they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && bus.upd_valid_i && bus.upd_taken_i) begin
            targets[upd_idx] <= bus.upd_target_i;
            if (!upd_hit) begin
                tags[upd_idx] <= upd_tag;
            end
        end
    end
endmodule
